// File: rtl/piano_pkg.sv
// Shared definitions for the keyboard note encoder.
// Holds the PS/2 special scan codes, the piano note codes and the keymap
// lookup that translates a PS/2 set-2 make code into a 6-bit note code.
// The optional build macro PS2_PARITY_CHECK_EN is consumed by ps2_rx_frame.
package piano_pkg;

  localparam logic [5:0] NOTE_STOP  = 6'h3F;
  localparam logic [7:0] SCAN_BREAK = 8'hF0;
  localparam logic [7:0] SCAN_EXT   = 8'hE0;

  localparam logic [5:0] NOTE_C4  = 6'd11;
  localparam logic [5:0] NOTE_CS4 = 6'd12;
  localparam logic [5:0] NOTE_D4  = 6'd13;
  localparam logic [5:0] NOTE_DS4 = 6'd14;
  localparam logic [5:0] NOTE_E4  = 6'd15;
  localparam logic [5:0] NOTE_F4  = 6'd16;
  localparam logic [5:0] NOTE_FS4 = 6'd17;
  localparam logic [5:0] NOTE_G4  = 6'd18;
  localparam logic [5:0] NOTE_GS4 = 6'd19;
  localparam logic [5:0] NOTE_A4  = 6'd20;
  localparam logic [5:0] NOTE_AS4 = 6'd21;
  localparam logic [5:0] NOTE_B4  = 6'd22;
  localparam logic [5:0] NOTE_C5  = 6'd23;

  typedef struct packed {
    logic       hit;
    logic [5:0] code;
  } keymap_t;

  function automatic keymap_t key_lookup(input logic [7:0] scan);
    keymap_t r;
    r.hit  = 1'b1;
    r.code = NOTE_STOP;
    case (scan)
      8'h1C:   r.code = NOTE_C4;
      8'h1D:   r.code = NOTE_CS4;
      8'h1B:   r.code = NOTE_D4;
      8'h24:   r.code = NOTE_DS4;
      8'h23:   r.code = NOTE_E4;
      8'h2B:   r.code = NOTE_F4;
      8'h2C:   r.code = NOTE_FS4;
      8'h34:   r.code = NOTE_G4;
      8'h35:   r.code = NOTE_GS4;
      8'h33:   r.code = NOTE_A4;
      8'h3C:   r.code = NOTE_AS4;
      8'h3B:   r.code = NOTE_B4;
      8'h42:   r.code = NOTE_C5;
      default: r.hit  = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keyboard_note_encoder_if.sv
// Bundle of the keyboard note encoder's external signals.
//   ps2_clk, ps2_data : raw PS/2 lines (asynchronous to the system clock)
//   note              : held note code, 6'h3F = stop
//   note_valid        : one-cycle pulse when note changes
//   frame_err         : one-cycle pulse when a PS/2 frame is dropped
// master = keyboard/consumer side, slave = encoder side.
interface keyboard_note_encoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [5:0] note;
  logic       note_valid;
  logic       frame_err;

  modport master (output ps2_clk, output ps2_data,
                  input  note, input note_valid, input frame_err);
  modport slave  (input  ps2_clk, input ps2_data,
                  output note, output note_valid, output frame_err);
endinterface

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: synchronizes the raw PS/2 lines, detects falling
// edges of ps2_clk and assembles start/8 data/parity/stop frames.
//   clk, rst     : system clock, asynchronous active-high reset
//   ps2_clk      : raw PS/2 clock
//   ps2_data     : raw PS/2 data
//   rx_byte      : last received data byte (valid with byte_valid)
//   byte_valid   : one-cycle pulse for a good frame
//   frame_err    : one-cycle pulse for a dropped frame
// A partial frame is abandoned silently after TIMEOUT_CYCLES clk cycles
// without a falling edge. Define PS2_PARITY_CHECK_EN to reject frames
// without odd parity; otherwise the parity bit is ignored.
module ps2_rx_frame
  import piano_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  logic            clk_meta, clk_s, clk_d;
  logic            dat_meta, dat_s;
  logic            fall;

  rx_state_t       state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            bv_q, bv_d;
  logic            fe_q, fe_d;
  logic            frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic            par_q, par_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_meta <= 1'b1;
      clk_s    <= 1'b1;
      clk_d    <= 1'b1;
      dat_meta <= 1'b1;
      dat_s    <= 1'b1;
    end else begin
      clk_meta <= ps2_clk;
      clk_s    <= clk_meta;
      clk_d    <= clk_s;
      dat_meta <= ps2_data;
      dat_s    <= dat_meta;
    end
  end

  assign fall = clk_d & ~clk_s;

`ifdef PS2_PARITY_CHECK_EN
  assign frame_ok = dat_s & (^{sr_q, par_q});
`else
  assign frame_ok = dat_s;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      tmo_q   <= '0;
      bv_q    <= 1'b0;
      fe_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      tmo_q   <= tmo_d;
      bv_q    <= bv_d;
      fe_q    <= fe_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    tmo_d   = tmo_q;
    bv_d    = 1'b0;
    fe_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d   = par_q;
`endif

    // Watchdog only runs inside a frame; a silent stall returns to IDLE
    // without reporting an error.
    if (state_q != IDLE && !fall) begin
      if (tmo_q == TMO_LAST) begin
        state_d = IDLE;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end

    if (fall) begin
      tmo_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          sr_d  = {dat_s, sr_q[7:1]};
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = dat_s;
`endif
          state_d = STOP;
        end
        STOP: begin
          bv_d    = frame_ok;
          fe_d    = ~frame_ok;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign rx_byte    = sr_q;
  assign byte_valid = bv_q;
  assign frame_err  = fe_q;

endmodule

// File: rtl/keyboard_note_encoder.sv
// PS/2 keyboard to piano note encoder.
//   clk, rst : system clock, asynchronous active-high reset
//   bus      : keyboard_note_encoder_if.slave (ps2_clk, ps2_data in;
//              note, note_valid, frame_err out)
// Decodes make/break/extended scan sequences; a mapped make sets the held
// note, releasing the held key sets note to stop (6'h3F). Typematic repeats
// and extended keys are ignored. PS2_PARITY_CHECK_EN enables parity checking
// in the frame receiver.
module keyboard_note_encoder
  import piano_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 20000
) (
  input  logic                  clk,
  input  logic                  rst,
  keyboard_note_encoder_if.slave bus
);

  typedef enum logic [1:0] {MAKE, BREAK, EXT} dec_state_t;

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  keymap_t    km;

  dec_state_t dec_q, dec_d;
  logic [5:0] note_q, note_d;
  logic [7:0] held_q, held_d;
  logic       nv_q, nv_d;

  ps2_rx_frame #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (bus.ps2_clk),
    .ps2_data   (bus.ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (rx_valid),
    .frame_err  (rx_err)
  );

  assign km = key_lookup(rx_byte);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_q  <= MAKE;
      note_q <= NOTE_STOP;
      held_q <= '0;
      nv_q   <= 1'b0;
    end else begin
      dec_q  <= dec_d;
      note_q <= note_d;
      held_q <= held_d;
      nv_q   <= nv_d;
    end
  end

  always_comb begin
    dec_d  = dec_q;
    note_d = note_q;
    held_d = held_q;
    nv_d   = 1'b0;
    if (rx_valid) begin
      case (dec_q)
        MAKE: begin
          if (rx_byte == SCAN_BREAK) begin
            dec_d = BREAK;
          end else if (rx_byte == SCAN_EXT) begin
            dec_d = EXT;
          end else if (km.hit && rx_byte != held_q) begin
            note_d = km.code;
            held_d = rx_byte;
            nv_d   = 1'b1;
          end
        end
        BREAK: begin
          // held_q of zero means nothing held; 0x00 is never a mapped key
          if (held_q != '0 && rx_byte == held_q) begin
            note_d = NOTE_STOP;
            held_d = '0;
            nv_d   = 1'b1;
          end
          dec_d = MAKE;
        end
        EXT: begin
          // E0 F0 xx: the F0 keeps us here so xx is swallowed too
          if (rx_byte != SCAN_BREAK) dec_d = MAKE;
        end
        default: dec_d = MAKE;
      endcase
    end
  end

  assign bus.note       = note_q;
  assign bus.note_valid = nv_q;
  assign bus.frame_err  = rx_err;

endmodule

// File: tb/tb_keyboard_note_encoder.sv
module tb_keyboard_note_encoder;

  localparam int unsigned TMO  = 200;
  localparam int unsigned HALF = 10;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   nv_cnt;
  int   fe_cnt;

  keyboard_note_encoder_if bus ();

  keyboard_note_encoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.note_valid) nv_cnt++;
    if (bus.frame_err)  fe_cnt++;
  end

  task automatic wait_cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Sends up to 11 bits of a PS/2 frame: start, data LSB-first, parity, stop.
  task automatic send_frame(input logic [7:0] b, input bit bad_par,
                            input bit stop_bit, input int unsigned nbits);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ bad_par, b, 1'b0};
    for (int unsigned i = 0; i < nbits; i++) begin
      bus.ps2_data = fr[i];
      wait_cycles(HALF);
      bus.ps2_clk = 1'b0;
      wait_cycles(HALF);
      bus.ps2_clk = 1'b1;
    end
    bus.ps2_data = 1'b1;
    wait_cycles(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b1, 11);
  endtask

  task automatic chk_note(input string name, input logic [5:0] exp);
    checks++;
    if (bus.note !== exp) begin
      errors++;
      $display("FAIL %s note=%0d expected %0d", name, bus.note, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s count=%0d expected %0d", name, act, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cycles(5);
    chk_note("reset_note", 6'h3F);
    checks++;
    if (bus.note_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_note_valid got %b expected 0", bus.note_valid);
    end
    checks++;
    if (bus.frame_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_frame_err got %b expected 0", bus.frame_err);
    end
    rst = 1'b0;
    wait_cycles(5);
  endtask

  task automatic test_make();
    int nv0;
    nv0 = nv_cnt;
    send_byte(8'h1C);
    chk_note("make_note", 6'd11);
    chk_cnt("make_pulse", nv_cnt - nv0, 1);
    nv0 = nv_cnt;
    for (int k = 0; k < 3; k++) send_byte(8'h1C);
    chk_note("repeat_note", 6'd11);
    chk_cnt("repeat_pulse", nv_cnt - nv0, 0);
  endtask

  task automatic test_break();
    int nv0, fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_byte(8'hF0);
    send_byte(8'h1D);
    chk_note("break_other_note", 6'd11);
    chk_cnt("break_other_pulse", nv_cnt - nv0, 0);
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk_note("break_held_note", 6'h3F);
    chk_cnt("break_held_pulse", nv_cnt - nv0, 1);
    chk_cnt("break_frame_err", fe_cnt - fe0, 0);
  endtask

  task automatic test_parity();
    int nv0, fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
    chk_cnt("parity_frame_err", fe_cnt - fe0, 1);
    chk_note("parity_note", 6'h3F);
    chk_cnt("parity_pulse", nv_cnt - nv0, 0);
`else
    chk_cnt("parity_frame_err", fe_cnt - fe0, 0);
    chk_note("parity_note", 6'd11);
    chk_cnt("parity_pulse", nv_cnt - nv0, 1);
`endif
    send_byte(8'hF0);
    send_byte(8'h1C);
    chk_note("parity_release", 6'h3F);
  endtask

  task automatic test_stop_error();
    int nv0, fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1B, 1'b0, 1'b0, 11);
    chk_cnt("stop_err_frame_err", fe_cnt - fe0, 1);
    chk_cnt("stop_err_pulse", nv_cnt - nv0, 0);
    chk_note("stop_err_note", 6'h3F);
  endtask

  task automatic test_timeout();
    int nv0, fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b1, 5);
    wait_cycles(TMO + 1);
    send_byte(8'h24);
    chk_note("timeout_note", 6'd14);
    chk_cnt("timeout_frame_err", fe_cnt - fe0, 0);
    chk_cnt("timeout_pulse", nv_cnt - nv0, 1);
  endtask

  task automatic test_ext();
    int nv0, fe0;
    nv0 = nv_cnt;
    fe0 = fe_cnt;
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    chk_note("ext_note", 6'd14);
    chk_cnt("ext_pulse", nv_cnt - nv0, 0);
    chk_cnt("ext_frame_err", fe_cnt - fe0, 0);
    send_byte(8'h42);
    chk_note("after_ext_note", 6'd23);
  endtask

  task automatic test_reset_mid_frame();
    int fe0;
    send_frame(8'h33, 1'b0, 1'b1, 6);
    rst = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    wait_cycles(3);
    chk_note("midrst_note", 6'h3F);
    rst = 1'b0;
    wait_cycles(3);
    fe0 = fe_cnt;
    send_byte(8'h1B);
    chk_note("midrst_after_note", 6'd13);
    chk_cnt("midrst_frame_err", fe_cnt - fe0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nv_cnt = 0;
    fe_cnt = 0;
    test_reset();
    test_make();
    test_break();
    test_parity();
    test_stop_error();
    test_timeout();
    test_ext();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
